// File: rtl/udiv64_pkg.sv
// Shared definitions for the radix-2 restoring divider: FSM state encodings
// and the default operand width, which the multiplier also uses.
package udiv64_pkg;
  localparam int UDIV_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/udiv_step.sv
// One restoring-division iteration: shift in the next dividend bit, then
// subtract the divisor if it fits.
module udiv_step
  import udiv64_pkg::*;
#(
  parameter int WIDTH = UDIV_WIDTH
) (
  input  logic [WIDTH-1:0] r,
  input  logic             din,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] r_nxt,
  output logic             qbit
);
  // The remainder is always below the divisor, so WIDTH bits hold it.
  // Only the shifted value t needs the extra bit.
  logic [WIDTH:0] t;

  assign t     = {r, din};
  assign qbit  = (t >= {1'b0, divisor});
  assign r_nxt = qbit ? WIDTH'(t - {1'b0, divisor}) : t[WIDTH-1:0];
endmodule

// File: rtl/udiv64.sv
// Multi-cycle unsigned divider with a start/busy/done handshake. It produces
// one quotient bit per clock, and the outputs update only on completion.
module udiv64
  import udiv64_pkg::*;
#(
  parameter int WIDTH = UDIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] q_work, r_work, dvsr, r_nxt;
  logic             qbit, accept, zero_div;

  udiv_step #(.WIDTH(WIDTH)) u_step (
    .r       (r_work),
    .din     (q_work[WIDTH-1]),
    .divisor (dvsr),
    .r_nxt   (r_nxt),
    .qbit    (qbit)
  );

  always_comb begin
    accept    = start && (state != CALC);
    zero_div  = (divisor == '0);
    state_nxt = state;
    busy      = (state == CALC);
    done      = (state == DONE);
    case (state)
      IDLE:    if (accept) state_nxt = zero_div ? DONE : CALC;
      CALC:    if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = accept ? (zero_div ? DONE : CALC) : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      q_work      <= '0;
      r_work      <= '0;
      dvsr        <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      if (zero_div) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end else begin
        q_work <= dividend;
        dvsr   <= divisor;
        r_work <= '0;
        cnt    <= CW'(WIDTH - 1);
      end
    end else if (state == CALC) begin
      // q_work shifts dividend bits out of the top and quotient bits in at the bottom.
      q_work <= {q_work[WIDTH-2:0], qbit};
      r_work <= r_nxt;
      cnt    <= cnt - CW'(1);
      if (cnt == '0) begin
        quotient    <= {q_work[WIDTH-2:0], qbit};
        remainder   <= r_nxt;
        div_by_zero <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_udiv64.sv
// Directed and random checks of udiv64 with a scoreboard of expected results.
module tb_udiv64;
  logic        clk, rst_n, start;
  logic [63:0] dividend, divisor;
  logic        busy, done, div_by_zero;
  logic [63:0] quotient, remainder;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [63:0] a, b, q, r;
    logic        dbz;
    int          lat;
  } exp_t;
  exp_t sb[$];

  udiv64 #(.WIDTH(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_res(input logic [63:0] a, b, q, r, input logic dbz, input int lat);
    exp_t e;
    e.a = a; e.b = b; e.q = q; e.r = r; e.dbz = dbz; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic drive_start(input logic [63:0] a, b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // Count cycles after the start edge until done; optionally pulse start
  // with unrelated operands at two chosen cycles.
  task automatic wait_done(input int p1, p2, output int lat, output int bc);
    lat = 0;
    bc  = 0;
    while (!done && lat < 200) begin
      if (busy) bc++;
      start = (lat == p1) || (lat == p2);
      if (start) begin
        dividend = 64'd77;
        divisor  = 64'd5;
      end
      tick();
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic finish_op(input string tag, input int p1, input int p2);
    int   lat, bc;
    exp_t e;
    wait_done(p1, p2, lat, bc);
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".lat"},  64'(lat), 64'(e.lat));
    chk({tag, ".busy"}, 64'(bc),  64'(e.lat));
    chk({tag, ".q"},    quotient,  e.q);
    chk({tag, ".r"},    remainder, e.r);
    chk({tag, ".dbz"},  64'(div_by_zero), 64'(e.dbz));
    if (e.b != 0) begin
      chk({tag, ".mul"},  quotient * e.b + remainder, e.a);
      chk({tag, ".rlt"},  64'(remainder < e.b), 64'd1);
    end
  endtask

  task automatic check_idle(input string tag);
    tick();
    chk({tag, ".done_off"}, 64'(done), 64'd0);
    chk({tag, ".busy_off"}, 64'(busy), 64'd0);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, ".busy"}, 64'(busy), 64'd0);
    chk({tag, ".done"}, 64'(done), 64'd0);
    chk({tag, ".q"},    quotient,  64'd0);
    chk({tag, ".r"},    remainder, 64'd0);
    chk({tag, ".dbz"},  64'(div_by_zero), 64'd0);
  endtask

  initial begin
    logic [63:0] a, b;
    int dones;

    // Reset with a simultaneous divide-by-zero start: reset must win.
    rst_n = 1'b0; start = 1'b1; dividend = 64'd5; divisor = 64'd0;
    repeat (3) tick();
    check_cleared("reset");
    start = 1'b0; rst_n = 1'b1;
    tick();

    expect_res(100, 7, 14, 2, 1'b0, 64);
    drive_start(100, 7);
    finish_op("d100_7", -1, -1);
    check_idle("d100_7");

    expect_res(64'h1234, 0, '1, 64'h1234, 1'b1, 0);
    drive_start(64'h1234, 0);
    finish_op("dbz", -1, -1);
    check_idle("dbz");

    expect_res('1, 1, '1, 0, 1'b0, 64);
    drive_start('1, 1);
    finish_op("max_1", -1, -1);
    check_idle("max_1");

    expect_res(5, 9, 0, 5, 1'b0, 64);
    drive_start(5, 9);
    finish_op("d5_9", -1, -1);

    expect_res(0, 3, 0, 0, 1'b0, 64);
    drive_start(0, 3);
    finish_op("d0_3", -1, -1);
    check_idle("d0_3");

    // Starts pulsed mid-operation must be ignored.
    expect_res(1000, 10, 100, 0, 1'b0, 64);
    drive_start(1000, 10);
    finish_op("ignore", 10, 40);
    check_idle("ignore");

    // Back-to-back: start issued during the DONE cycle.
    expect_res(100, 7, 14, 2, 1'b0, 64);
    drive_start(100, 7);
    finish_op("b2b_a", -1, -1);
    expect_res(81, 9, 9, 0, 1'b0, 64);
    drive_start(81, 9);
    finish_op("b2b_b", -1, -1);
    check_idle("b2b_b");

    // Abort in the middle of an operation.
    drive_start(1000000, 3);
    repeat (30) tick();
    chk("abort.busy_pre", 64'(busy), 64'd1);
    rst_n = 1'b0;
    tick();
    check_cleared("abort");
    rst_n = 1'b1;
    dones = 0;
    repeat (80) begin
      tick();
      if (done) dones++;
    end
    chk("abort.no_done", 64'(dones), 64'd0);

    expect_res(50, 6, 8, 2, 1'b0, 64);
    drive_start(50, 6);
    finish_op("d50_6", -1, -1);
    check_idle("d50_6");

    for (int i = 0; i < 16; i++) begin
      a = 64'($urandom) & 64'hFF;
      b = 64'($urandom) & 64'hFF;
      if (i % 2 == 1) b = b << 32;
      if (b == 0) expect_res(a, b, '1, a, 1'b1, 0);
      else        expect_res(a, b, a / b, a % b, 1'b0, 64);
      drive_start(a, b);
      finish_op($sformatf("rnd%0d", i), -1, -1);
      check_idle($sformatf("rnd%0d", i));
    end

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
